isqrt_seq: RTL and testbench

ISQRT_SEQ -- requirements
Module: isqrt_seq

---
 rtl/isqrt_seq.sv | 118 +++++++++++
 tb/tb_isqrt_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_seq.sv
// Sequential integer square root: restoring digit recurrence, STEPS root bits per clock.
// root = floor(sqrt(x)), rem = x - root^2, exact flags a perfect square.
module isqrt_seq #(
    parameter int WIDTH = 64,
    parameter int STEPS = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic               exact
);

    localparam int HALF = WIDTH / 2;
    localparam int M    = HALF / STEPS;
    localparam int CW   = $clog2(M + 1);
    localparam int RW   = HALF + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] rad_reg;
    logic [HALF-1:0]  proot_reg;
    logic [RW-1:0]    prem_reg;
    logic [CW-1:0]    count_reg;
    logic [HALF-1:0]  root_reg;
    logic [HALF:0]    rem_reg;
    logic             exact_reg;

    logic accept;
    logic last_step;

    assign accept    = start && (state_reg != RUN);
    assign last_step = (state_reg == RUN) && (count_reg == CW'(1));

    // Combinational chain of STEPS recurrence stages, fed from the partial state.
    logic [HALF-1:0]  root_s [0:STEPS];
    logic [RW-1:0]    rem_s  [0:STEPS];
    logic [WIDTH-1:0] rad_s  [0:STEPS];

    assign root_s[0] = proot_reg;
    assign rem_s[0]  = prem_reg;
    assign rad_s[0]  = rad_reg;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_stage
            logic [RW-1:0] shifted;
            logic [RW-1:0] trial;
            logic          ge;

            // Partial remainder never exceeds 2*root, so its top two bits are zero here.
            assign shifted = {rem_s[gi][RW-3:0], rad_s[gi][WIDTH-1 -: 2]};
            assign trial   = {root_s[gi], 2'b01};
            assign ge      = (shifted >= trial);

            assign rem_s[gi+1]  = ge ? (shifted - trial) : shifted;
            assign root_s[gi+1] = {root_s[gi][HALF-2:0], ge};
            assign rad_s[gi+1]  = {rad_s[gi][WIDTH-3:0], 2'b00};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rad_reg   <= '0;
            proot_reg <= '0;
            prem_reg  <= '0;
            count_reg <= '0;
            root_reg  <= '0;
            rem_reg   <= '0;
            exact_reg <= 1'b0;
        end else if (accept) begin
            rad_reg   <= x;
            proot_reg <= '0;
            prem_reg  <= '0;
            count_reg <= CW'(M);
        end else if (state_reg == RUN) begin
            rad_reg   <= rad_s[STEPS];
            proot_reg <= root_s[STEPS];
            prem_reg  <= rem_s[STEPS];
            count_reg <= count_reg - CW'(1);
            // Published results change only on the edge that enters DONE.
            if (last_step) begin
                root_reg  <= root_s[STEPS];
                rem_reg   <= rem_s[STEPS][HALF:0];
                exact_reg <= (rem_s[STEPS] == '0);
            end
        end
    end

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign root  = root_reg;
    assign rem   = rem_reg;
    assign exact = exact_reg;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq across several WIDTH/STEPS configurations,
// compared against a multiply-based binary-search square root model.
module tb_isqrt_seq;

    localparam int NI = 5;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 64;
            1:       return 16;
            2:       return 32;
            3:       return 8;
            default: return 128;
        endcase
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 4;
            default: return 2;
        endcase
    endfunction

    logic          clk;
    logic          reset;
    logic [NI-1:0] start_w;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;
    logic [NI-1:0] exact_w;
    logic [127:0]  x_bus;
    logic [63:0]   root_w [NI];
    logic [64:0]   rem_w  [NI];

    int n_vec = 0;
    int n_err = 0;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int W = cfg_w(gi);
            localparam int S = cfg_s(gi);
            logic [W/2-1:0] r;
            logic [W/2:0]   rm;

            isqrt_seq #(.WIDTH(W), .STEPS(S)) u_dut (
                .clk   (clk),
                .reset (reset),
                .start (start_w[gi]),
                .x     (x_bus[W-1:0]),
                .busy  (busy_w[gi]),
                .done  (done_w[gi]),
                .root  (r),
                .rem   (rm),
                .exact (exact_w[gi])
            );

            assign root_w[gi] = 64'(r);
            assign rem_w[gi]  = 65'(rm);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Largest r with r*r <= v, found bit by bit using plain multiplication.
    function automatic logic [127:0] ref_root(input logic [127:0] v);
        logic [127:0] r;
        logic [127:0] t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = r | (128'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input logic [127:0] xv);
        int           lat;
        int           m;
        logic [127:0] er;
        logic [127:0] erem;
        m    = cfg_w(idx) / (2 * cfg_s(idx));
        er   = ref_root(xv);
        erem = xv - er * er;
        x_bus = xv;
        start_w[idx] = 1'b1;
        tick();
        start_w[idx] = 1'b0;
        check_val("busy_run", 128'(busy_w[idx]), 128'd1);
        lat = 0;
        while (done_w[idx] !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        check_val("latency", 128'(lat), 128'(m));
        check_val("root", 128'(root_w[idx]), er);
        check_val("rem", 128'(rem_w[idx]), erem);
        check_val("exact", 128'(exact_w[idx]), 128'(erem == 128'd0));
        check_val("busy_done", 128'(busy_w[idx]), 128'd0);
        $display("inst%0d W=%0d S=%0d x=%0h root=%0h rem=%0h exact=%0b lat=%0d",
                 idx, cfg_w(idx), cfg_s(idx), xv, root_w[idx], rem_w[idx], exact_w[idx], lat);
        tick();
        check_val("done_pulse", 128'(done_w[idx]), 128'd0);
    endtask

    initial begin
        int           dcount;
        logic [127:0] xv;
        logic [127:0] mask;

        reset   = 1'b1;
        start_w = '0;
        x_bus   = '0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            check_val("rst_busy", 128'(busy_w[i]), 128'd0);
            check_val("rst_done", 128'(done_w[i]), 128'd0);
            check_val("rst_root", 128'(root_w[i]), 128'd0);
            check_val("rst_rem", 128'(rem_w[i]), 128'd0);
            check_val("rst_exact", 128'(exact_w[i]), 128'd0);
        end
        $display("reset applied to %0d instances", NI);
        reset = 1'b0;
        tick();

        // Boundary radicands and the reference example on the 64-bit, 1-bit-per-cycle unit
        run_op(0, 128'd0);
        run_op(0, 128'(64'hFFFF_FFFF_FFFF_FFFF));
        check_val("max_root", 128'(root_w[0]), 128'h0_FFFF_FFFF);
        check_val("max_rem", 128'(rem_w[0]), 128'h1_FFFF_FFFE);
        run_op(0, 128'd213213123244);
        check_val("ex_root", 128'(root_w[0]), 128'd461750);
        check_val("ex_rem", 128'(rem_w[0]), 128'd60744);

        // Reset five cycles into a computation, with a coincident start that must be ignored
        x_bus = 128'd1000000007;
        start_w[0] = 1'b1;
        tick();
        start_w[0] = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        x_bus = 128'd49;
        start_w[0] = 1'b1;
        tick();
        reset = 1'b0;
        start_w[0] = 1'b0;
        check_val("abort_busy", 128'(busy_w[0]), 128'd0);
        check_val("abort_root", 128'(root_w[0]), 128'd0);
        check_val("abort_rem", 128'(rem_w[0]), 128'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_w[0] === 1'b1) dcount++;
            tick();
        end
        check_val("abort_nodone", 128'(dcount), 128'd0);
        $display("abort sequence: done pulses after reset=%0d", dcount);
        run_op(0, 128'd49);
        check_val("post_abort_root", 128'(root_w[0]), 128'd7);

        // 16-bit, 2-bits-per-cycle unit
        run_op(1, 128'd144);
        check_val("r144_root", 128'(root_w[1]), 128'd12);
        run_op(1, 128'd65535);
        check_val("r65535_root", 128'(root_w[1]), 128'd255);
        check_val("r65535_rem", 128'(rem_w[1]), 128'd510);

        // Start ignored mid-run, then back-to-back restart from the DONE cycle
        x_bus = 128'd144;
        start_w[1] = 1'b1;
        tick();
        start_w[1] = 1'b0;
        tick();
        x_bus = 128'd100;
        start_w[1] = 1'b1;
        tick();
        start_w[1] = 1'b0;
        tick();
        tick();
        check_val("b2b_done1", 128'(done_w[1]), 128'd1);
        check_val("b2b_root1", 128'(root_w[1]), 128'd12);
        $display("inst1 first of back-to-back: root=%0d rem=%0d", root_w[1], rem_w[1]);
        x_bus = 128'd99;
        start_w[1] = 1'b1;
        tick();
        start_w[1] = 1'b0;
        check_val("b2b_busy", 128'(busy_w[1]), 128'd1);
        check_val("b2b_hold", 128'(root_w[1]), 128'd12);
        repeat (4) tick();
        check_val("b2b_done2", 128'(done_w[1]), 128'd1);
        check_val("b2b_root2", 128'(root_w[1]), 128'd9);
        check_val("b2b_rem2", 128'(rem_w[1]), 128'd18);
        check_val("b2b_exact2", 128'(exact_w[1]), 128'd0);
        $display("inst1 second of back-to-back: root=%0d rem=%0d", root_w[1], rem_w[1]);
        tick();

        // Randomized radicands for every configuration
        for (int i = 0; i < NI; i++) begin
            mask = (cfg_w(i) == 128) ? {128{1'b1}} : ((128'd1 << cfg_w(i)) - 128'd1);
            for (int k = 0; k < 12; k++) begin
                xv = {$urandom, $urandom, $urandom, $urandom};
                if (k == 0) xv = '1;
                run_op(i, xv & mask);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
